// File: rtl/wb_burst_master_if.sv
// rtl/wb_burst_master_if.sv - command handshake and Wishbone B3 bus bundle for wb_burst_master
interface wb_burst_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_addr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [2:0]  wb_cti_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i, wb_dat_i, wb_ack_i,
        output cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o,
               wb_dat_o, wb_cti_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i, wb_dat_i, wb_ack_i,
        input  cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o,
               wb_dat_o, wb_cti_o
    );
endinterface

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - Wishbone incrementing-burst master with address-pattern data and read checking
module wb_burst_master #(
    parameter logic [31:0] SEED    = 32'hA5A5_0000,
    parameter int          TIMEOUT = 1024
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_burst_master_if.master         bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [15:0]               err_cnt_o
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    state_t        state_q;
    logic          cyc_q, we_q, cmd_ready_q, busy_q, done_q, timeout_q;
    logic [31:0]   addr_q, dat_q;
    logic [2:0]    cti_q;
    logic [3:0]    sel_q;
    logic [8:0]    rem_q;
    logic [WD_W-1:0] wdog_q;
    logic [15:0]   err_cnt_q;

    logic [31:0]   start_addr, addr_d;
    logic [8:0]    start_len, rem_d;
    logic [15:0]   err_d;
    logic          mismatch;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a & ~32'h3) ^ SEED;
    endfunction

    always_comb begin
        start_addr = bus.cmd_addr_i & ~32'h3;
        start_len  = (bus.cmd_len_i == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len_i};
        addr_d     = addr_q + 32'd4;
        rem_d      = rem_q - 9'd1;
        mismatch   = !we_q && (bus.wb_dat_i != pat(addr_q));
        err_d      = (mismatch && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'h0;
            cti_q       <= 3'b000;
            rem_q       <= 9'd0;
            wdog_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        we_q        <= bus.cmd_we_i;
                        addr_q      <= start_addr;
                        dat_q       <= pat(start_addr);
                        rem_q       <= start_len;
                        cti_q       <= (start_len == 9'd1) ? 3'b000 : 3'b010;
                        sel_q       <= 4'hF;
                        wdog_q      <= '0;
                        cyc_q       <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_BURST;
                    end
                end
                S_BURST: begin
                    // an ack wins over a watchdog expiring on the same edge
                    if (bus.wb_ack_i) begin
                        err_cnt_q <= err_d;
                        wdog_q    <= '0;
                        addr_q    <= addr_d;
                        dat_q     <= pat(addr_d);
                        rem_q     <= rem_d;
                        if (rem_q == 9'd1) begin
                            cyc_q   <= 1'b0;
                            sel_q   <= 4'h0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cti_q <= (rem_d == 9'd1) ? 3'b111 : 3'b010;
                        end
                    end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                        cyc_q     <= 1'b0;
                        sel_q     <= 4'h0;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_DONE: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_addr_o   = addr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_cti_o    = cti_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign timeout_o       = timeout_q;
    assign err_cnt_o       = err_cnt_q;
endmodule
